see_dispatcher: RTL and testbench

SEE_DISPATCHER -- requirements
Module: see_dispatcher

---
 rtl/see_dispatcher_pkg.sv | 36 +++
 rtl/rdy_vld_if.sv | 11 +
 rtl/see_fifo.sv | 59 +++++
 rtl/see_dispatcher.sv | 149 ++++++++++++++
 tb/tb_see_dispatcher.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/see_dispatcher_pkg.sv
// Shared types and constants for the see dispatcher: payload layout, destination
// encoding, output count and delivered-beat counter width.
package mixedBlockC_package;

   localparam int NUM_SEE    = 3;
   localparam int ACC_CNT_W  = 16;
   localparam int SEE_DATA_W = 32;

   // Destination field carried in the top two bits of every request beat.
   typedef enum logic [1:0] {
      SEE_DEST_0  = 2'd0,
      SEE_DEST_1  = 2'd1,
      SEE_DEST_2  = 2'd2,
      SEE_DEST_RR = 2'd3
   } see_dest_e;

   // Request payload as it appears on the upstream stream (default width).
   typedef struct packed {
      see_dest_e               dest;
      logic [SEE_DATA_W-1:0]   data;
   } see_req_t;

   typedef logic [ACC_CNT_W-1:0] acc_cnt_t;

   // Next output index in round-robin order, wrapping 2 -> 0.
   function automatic logic [1:0] see_rr_next(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rdy_vld_if.sv
// Valid/ready stream bundle; src drives vld/data, dst drives rdy.
interface rdy_vld_if #(
   parameter int W = 32
);
   logic         vld;
   logic         rdy;
   logic [W-1:0] data;

   modport src (output vld, output data, input rdy);
   modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/see_fifo.sv
// Small synchronous FIFO used as one output queue of the dispatcher.
// Head entry is presented directly from storage, so a pushed beat becomes
// visible one cycle after it is written.
module see_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic              nempty_o,
   output logic              full_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   // Storage, pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_q        <= wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_q <= rd_ptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o   = mem_q[rd_ptr_q];
   assign nempty_o = (count_q != CW'(0));
   assign full_o   = (count_q == CW'(FIFO_DEPTH));

endmodule

// File: rtl/see_dispatcher.sv
// Routes beats from one upstream see stream into three output queues, either
// directly by destination or round-robin over non-full queues, and counts the
// beats delivered on each output.
module see_dispatcher
   import mixedBlockC_package::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rdy_vld_if.dst               seeIn,
   rdy_vld_if.src               see0,
   rdy_vld_if.src               see1,
   rdy_vld_if.src               see2,
   output logic [ACC_CNT_W-1:0] accCnt0,
   output logic [ACC_CNT_W-1:0] accCnt1,
   output logic [ACC_CNT_W-1:0] accCnt2
);

   logic [NUM_SEE-1:0] full_s;
   logic [NUM_SEE-1:0] nempty_s;
   logic [NUM_SEE-1:0] pop_s;
   logic [NUM_SEE-1:0] push_s;
   logic [NUM_SEE-1:0] out_rdy_s;
   logic [3:0]         avail_s;
   logic [DATA_W-1:0]  head_s [NUM_SEE];
   logic [DATA_W-1:0]  in_data_s;
   logic [1:0]         dest_raw_s;
   see_dest_e          dest_s;
   logic [1:0]         cand0_s;
   logic [1:0]         cand1_s;
   logic [1:0]         cand2_s;
   logic [1:0]         sel_s;
   logic               sel_ok_s;
   logic               in_rdy_s;
   logic               accept_s;
   logic [1:0]         rr_ptr_q;
   logic [1:0]         rr_ptr_d;
   acc_cnt_t           acc_cnt_q [NUM_SEE];

   assign dest_raw_s = seeIn.data[DATA_W+1:DATA_W];
   assign dest_s     = see_dest_e'(dest_raw_s);
   assign in_data_s  = seeIn.data[DATA_W-1:0];
   assign out_rdy_s  = {see2.rdy, see1.rdy, see0.rdy};

   // Outputs are held idle while reset is asserted; a pop is a completed transfer.
   assign pop_s = nempty_s & out_rdy_s & {NUM_SEE{~rst_n}};

   // Destination selection, upstream ready and round-robin pointer next state.
   always_comb begin
      // A full queue can still take a beat when its head leaves in the same cycle.
      avail_s  = {1'b0, (~full_s) | pop_s};
      cand0_s  = rr_ptr_q;
      cand1_s  = see_rr_next(cand0_s);
      cand2_s  = see_rr_next(cand1_s);
      sel_s    = 2'd0;
      sel_ok_s = 1'b0;
      case (dest_s)
         SEE_DEST_RR: begin
            if (avail_s[cand0_s]) begin
               sel_s    = cand0_s;
               sel_ok_s = 1'b1;
            end else if (avail_s[cand1_s]) begin
               sel_s    = cand1_s;
               sel_ok_s = 1'b1;
            end else if (avail_s[cand2_s]) begin
               sel_s    = cand2_s;
               sel_ok_s = 1'b1;
            end else begin
               sel_s    = cand0_s;
               sel_ok_s = 1'b0;
            end
         end
         default: begin
            sel_s    = dest_raw_s;
            sel_ok_s = avail_s[dest_raw_s];
         end
      endcase
      in_rdy_s = sel_ok_s & ~rst_n;
      accept_s = seeIn.vld & in_rdy_s;
      if (accept_s) begin
         push_s = 3'b001 << sel_s;
      end else begin
         push_s = 3'b000;
      end
      if (accept_s && (dest_s == SEE_DEST_RR)) begin
         rr_ptr_d = see_rr_next(sel_s);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   assign seeIn.rdy = in_rdy_s;

   // Round-robin start position register.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rr_ptr_q <= 2'd0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Per-output delivered-beat counters, wrapping at the counter width.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_SEE; i++) begin
            acc_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SEE; i++) begin
            if (pop_s[i]) begin
               acc_cnt_q[i] <= acc_cnt_q[i] + ACC_CNT_W'(1);
            end else begin
               acc_cnt_q[i] <= acc_cnt_q[i];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SEE; g++) begin : g_q
      see_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk         (clk),
         .rst         (rst_n),
         .push_i      (push_s[g]),
         .push_data_i (in_data_s),
         .pop_i       (pop_s[g]),
         .head_o      (head_s[g]),
         .nempty_o    (nempty_s[g]),
         .full_o      (full_s[g])
      );
   end

   assign see0.vld  = nempty_s[0] & ~rst_n;
   assign see1.vld  = nempty_s[1] & ~rst_n;
   assign see2.vld  = nempty_s[2] & ~rst_n;
   assign see0.data = head_s[0];
   assign see1.data = head_s[1];
   assign see2.data = head_s[2];

   assign accCnt0 = acc_cnt_q[0];
   assign accCnt1 = acc_cnt_q[1];
   assign accCnt2 = acc_cnt_q[2];

endmodule

// File: tb/tb_see_dispatcher.sv
// Bench for see_dispatcher: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the dispatching rules.
module tb_see_dispatcher;

   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] acc0, acc1, acc2;

   rdy_vld_if #(.W(DW + 2)) in_if ();
   rdy_vld_if #(.W(DW))     o0 ();
   rdy_vld_if #(.W(DW))     o1 ();
   rdy_vld_if #(.W(DW))     o2 ();

   see_dispatcher #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst),
      .seeIn   (in_if),
      .see0    (o0),
      .see1    (o1),
      .see2    (o2),
      .accCnt0 (acc0),
      .accCnt1 (acc1),
      .accCnt2 (acc2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: one queue per output, round-robin start, counters.
   logic [DW-1:0] mq [3][$];
   int            m_rr;
   int            m_acc [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         m_acc[i] = 0;
      end
      m_rr = 0;
   endtask

   // One clock cycle: drive inputs, compare DUT against model, advance model.
   task automatic step(input logic r, input logic v, input logic [1:0] d,
                       input logic [DW-1:0] dat, input logic [2:0] rd);
      logic [2:0]    pop, avail, obs_v;
      logic [DW-1:0] obs_d [3];
      logic [15:0]   obs_c [3];
      logic          exp_rdy;
      int            tgt;
      @(negedge clk);
      rst        = r;
      in_if.vld  = v;
      in_if.data = {d, dat};
      o0.rdy     = rd[0];
      o1.rdy     = rd[1];
      o2.rdy     = rd[2];
      #1;
      obs_v = {o2.vld, o1.vld, o0.vld};
      obs_d[0] = o0.data; obs_d[1] = o1.data; obs_d[2] = o2.data;
      obs_c[0] = acc0;    obs_c[1] = acc1;    obs_c[2] = acc2;
      for (int i = 0; i < 3; i++) begin
         pop[i]   = !r && (mq[i].size() > 0) && rd[i];
         avail[i] = (mq[i].size() < DEPTH) || pop[i];
      end
      if (r) exp_rdy = 1'b0;
      else if (d == 2'd3) exp_rdy = |avail;
      else exp_rdy = avail[d];
      chk("in_rdy", {63'd0, in_if.rdy}, {63'd0, exp_rdy});
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("vld%0d", i), {63'd0, obs_v[i]}, {63'd0, (!r && mq[i].size() > 0)});
         if (!r && mq[i].size() > 0)
            chk($sformatf("data%0d", i), {32'd0, obs_d[i]}, {32'd0, mq[i][0]});
         chk($sformatf("acc%0d", i), {48'd0, obs_c[i]}, 64'(m_acc[i]));
      end
      if (r) begin
         model_clear();
      end else begin
         tgt = -1;
         if (v && exp_rdy) begin
            if (d != 2'd3) begin
               tgt = d;
            end else begin
               for (int k = 0; k < 3; k++) begin
                  if (tgt < 0 && avail[(m_rr + k) % 3]) tgt = (m_rr + k) % 3;
               end
               m_rr = (tgt + 1) % 3;
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (pop[i]) begin
               void'(mq[i].pop_front());
               m_acc[i] = (m_acc[i] + 1) % 65536;
            end
         end
         if (tgt >= 0) mq[tgt].push_back(dat);
      end
   endtask

   initial begin
      in_if.vld = 1'b0; in_if.data = '0;
      o0.rdy = 1'b0; o1.rdy = 1'b0; o2.rdy = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_clear();

      // Reset state.
      step(1'b1, 1'b1, 2'd0, 32'h1, 3'b111);
      step(1'b1, 1'b0, 2'd3, 32'h2, 3'b111);

      // Single direct beat to output 1.
      step(1'b0, 1'b1, 2'd1, 32'hA5, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);

      // Six round-robin beats, consumers always ready.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd3, 32'h100 + 32'(i), 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);

      // Back-pressure on output 2, then drain.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2, 32'h200 + 32'(i), 3'b011);
      step(1'b0, 1'b1, 2'd2, 32'h202, 3'b111);
      step(1'b0, 1'b1, 2'd2, 32'h202, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);

      // Full queue 0 with simultaneous pop and push.
      step(1'b0, 1'b1, 2'd0, 32'h300, 3'b110);
      step(1'b0, 1'b1, 2'd0, 32'h301, 3'b110);
      step(1'b0, 1'b1, 2'd0, 32'h302, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);

      // Queues 0 and 1 full, round-robin beat goes to queue 2.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'd0, 32'h400 + 32'(i), 3'b000);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'd1, 32'h410 + 32'(i), 3'b000);
      step(1'b0, 1'b1, 2'd3, 32'h420, 3'b000);
      step(1'b0, 1'b1, 2'd3, 32'h421, 3'b000);
      step(1'b0, 1'b1, 2'd3, 32'h422, 3'b000);

      // Reset with beats queued everywhere, then clean traffic.
      step(1'b1, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);
      step(1'b0, 1'b1, 2'd3, 32'h500, 3'b111);
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b111);

      // Random traffic with occasional reset.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 32'($urandom), 3'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
